// File: rtl/psmac_pkg.sv
// Shared types and helpers for the precision-scalable MAC: level type, lane and level counts,
// segment width and mode clamping.
package psmac_pkg;

  localparam int PSMAC_WGT_W   = 8;
  localparam int PSMAC_SLICE_W = 2;
  localparam int PSMAC_LANES   = PSMAC_WGT_W / PSMAC_SLICE_W;
  localparam int PSMAC_NLEV    = $clog2(PSMAC_LANES) + 1;
  localparam int PSMAC_LVL_W   = (PSMAC_NLEV > 1) ? $clog2(PSMAC_NLEV) : 1;

  typedef logic [PSMAC_LVL_W-1:0] lvl_t;

  function automatic int seg_width(input int acc_w, input int lvl);
    return acc_w >> lvl;
  endfunction

  function automatic int clamp_level(input int mode, input int nlev);
    return (mode >= nlev) ? nlev - 1 : mode;
  endfunction

endpackage

// File: rtl/psmac_slice_mult.sv
// Combinational ACT_W x SLICE_W multiplier; the slice is signed when i_sgn is set (top slice of a
// sub-weight) and unsigned otherwise.
module psmac_slice_mult #(
  parameter int ACT_W   = 8,
  parameter int SLICE_W = 2
) (
  input  logic signed [ACT_W-1:0]         i_act,
  input  logic        [SLICE_W-1:0]       i_slice,
  input  logic                            i_sgn,
  output logic signed [ACT_W+SLICE_W-1:0] o_prod
);

  localparam int PW = ACT_W + SLICE_W + 1;

  logic signed [SLICE_W:0] w_slice;
  logic signed [PW-1:0]    w_full;

  assign w_slice = {i_sgn & i_slice[SLICE_W-1], i_slice};
  assign w_full  = PW'(i_act) * PW'(w_slice);
  // The product always fits one bit narrower than the full multiply width.
  assign o_prod  = w_full[PW-2:0];

endmodule

// File: rtl/prec_scalable_mac.sv
// Precision-scalable MAC: 2-stage pipeline (product, then segmented accumulate), result one edge
// after the last beat; in_ready = !out_valid || out_ready. PSMAC_SATURATE_EN selects saturation.
module prec_scalable_mac
  import psmac_pkg::*;
#(
  parameter int ACT_W   = 8,
  parameter int WGT_W   = PSMAC_WGT_W,
  parameter int SLICE_W = PSMAC_SLICE_W,
  parameter int ACC_W   = 56,
  parameter int CNT_W   = 16,
  localparam int LANES  = WGT_W / SLICE_W,
  localparam int NLEV   = $clog2(LANES) + 1,
  localparam int LVL_W  = (NLEV > 1) ? $clog2(NLEV) : 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [LVL_W-1:0]     mode,
  input  logic [CNT_W-1:0]     acc_len,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [ACT_W-1:0]     act,
  input  logic [WGT_W-1:0]     wgt,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [ACC_W-1:0]     out_acc,
  output logic [LANES-1:0]     out_ovf
);

  logic [LVL_W-1:0] w_lvl, r_lvl, r_s1_lvl;
  logic [CNT_W-1:0] w_len, r_len, r_cnt;
  logic             w_last, w_acc, w_s2_go;
  logic             r_s1_vld, r_s1_last, r_out_vld;
  logic [ACC_W-1:0] w_prod, w_sum, r_s1_prod, r_acc, r_out_acc;
  logic [LANES-1:0] w_sgn;
  logic signed [ACT_W+SLICE_W-1:0] w_sp [LANES];
`ifdef PSMAC_SATURATE_EN
  localparam logic signed [ACC_W:0] ONE = 1;
  logic [LANES-1:0] w_ovf, r_ovf, r_out_ovf;
`endif

  assign in_ready  = !r_out_vld || out_ready;
  assign w_acc     = in_valid && in_ready;
  // Only a finished result needs the output register; partial sums keep flowing.
  assign w_s2_go   = r_s1_vld && !(r_s1_last && r_out_vld && !out_ready);
  assign w_lvl     = (r_cnt == '0) ? LVL_W'(clamp_level(int'(mode), NLEV)) : r_lvl;
  assign w_len     = (r_cnt == '0) ? ((acc_len == '0) ? CNT_W'(1) : acc_len) : r_len;
  assign w_last    = (r_cnt == w_len - CNT_W'(1));
  assign out_valid = r_out_vld;
  assign out_acc   = r_out_acc;

  always_comb begin
    w_sgn = '0;
    for (int j = 0; j < LANES; j++) begin
      w_sgn[j] = (((j + 1) % (LANES >> w_lvl)) == 0);
    end
  end

  for (genvar j = 0; j < LANES; j++) begin : g_slice
    psmac_slice_mult #(
      .ACT_W   (ACT_W),
      .SLICE_W (SLICE_W)
    ) u_slice (
      .i_act   (act),
      .i_slice (wgt[j*SLICE_W +: SLICE_W]),
      .i_sgn   (w_sgn[j]),
      .o_prod  (w_sp[j])
    );
  end

  // Shift-add the slice products of each sub-weight into its own segment.
  always_comb begin : p_prod
    logic signed [ACC_W-1:0] v_sum;
    int segw;
    w_prod = '0;
    v_sum  = '0;
    segw   = 0;
    for (int lv = 0; lv < NLEV; lv++) begin
      if (lv == int'(w_lvl)) begin
        segw = seg_width(ACC_W, lv);
        for (int k = 0; k < (1 << lv); k++) begin
          v_sum = '0;
          for (int i = 0; i < (LANES >> lv); i++) begin
            v_sum = v_sum + (ACC_W'(w_sp[k*(LANES >> lv) + i]) <<< (i * SLICE_W));
          end
          for (int b = 0; b < segw; b++) begin
            w_prod[k*segw + b] = v_sum[b];
          end
        end
      end
    end
  end

  // Per-segment add in one extra bit so overflow is visible before wrap or clamp.
  always_comb begin : p_acc
    logic signed [ACC_W:0] v_a, v_p, v_s;
    int segw, idx;
`ifdef PSMAC_SATURATE_EN
    logic signed [ACC_W:0] v_lim;
    w_ovf = '0;
    v_lim = '0;
`endif
    w_sum = '0;
    v_a   = '0;
    v_p   = '0;
    v_s   = '0;
    segw  = 0;
    idx   = 0;
    for (int lv = 0; lv < NLEV; lv++) begin
      if (lv == int'(r_s1_lvl)) begin
        segw = seg_width(ACC_W, lv);
        for (int k = 0; k < (1 << lv); k++) begin
          for (int b = 0; b <= ACC_W; b++) begin
            idx    = k * segw + ((b < segw) ? b : segw - 1);
            v_a[b] = r_acc[idx];
            v_p[b] = r_s1_prod[idx];
          end
          v_s = v_a + v_p;
`ifdef PSMAC_SATURATE_EN
          v_lim = '0;
          v_lim[segw-1] = 1'b1;
          if (v_s >= v_lim) begin
            v_s      = v_lim - ONE;
            w_ovf[k] = 1'b1;
          end else if (v_s < -v_lim) begin
            v_s      = -v_lim;
            w_ovf[k] = 1'b1;
          end
`endif
          for (int b = 0; b < segw; b++) begin
            w_sum[k*segw + b] = v_s[b];
          end
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt     <= '0;
      r_len     <= '0;
      r_lvl     <= '0;
      r_s1_vld  <= 1'b0;
      r_s1_last <= 1'b0;
      r_s1_lvl  <= '0;
      r_s1_prod <= '0;
      r_acc     <= '0;
      r_out_vld <= 1'b0;
      r_out_acc <= '0;
    end else begin
      if (w_acc) begin
        r_s1_vld  <= 1'b1;
        r_s1_prod <= w_prod;
        r_s1_lvl  <= w_lvl;
        r_s1_last <= w_last;
        r_cnt     <= w_last ? '0 : r_cnt + CNT_W'(1);
        r_lvl     <= w_lvl;
        r_len     <= w_len;
      end else if (w_s2_go) begin
        r_s1_vld  <= 1'b0;
      end
      if (r_out_vld && out_ready) begin
        r_out_vld <= 1'b0;
      end
      if (w_s2_go) begin
        if (r_s1_last) begin
          r_out_vld <= 1'b1;
          r_out_acc <= w_sum;
          r_acc     <= '0;
        end else begin
          r_acc     <= w_sum;
        end
      end
    end
  end

`ifdef PSMAC_SATURATE_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ovf     <= '0;
      r_out_ovf <= '0;
    end else if (w_s2_go) begin
      if (r_s1_last) begin
        r_out_ovf <= r_ovf | w_ovf;
        r_ovf     <= '0;
      end else begin
        r_ovf     <= r_ovf | w_ovf;
      end
    end
  end

  assign out_ovf = r_out_ovf;
`else
  assign out_ovf = '0;
`endif

endmodule

// File: tb/tb_prec_scalable_mac.sv
// Directed and randomized bench for prec_scalable_mac with an arithmetic per-segment reference model.
module tb_prec_scalable_mac;
  import psmac_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  lvl_t        mode;
  logic [15:0] acc_len;
  logic        in_valid, in_ready, out_valid, out_ready;
  logic [7:0]  act, wgt;
  logic [55:0] out_acc;
  logic [3:0]  out_ovf;

  int total = 0;
  int bad   = 0;
  bit rnd_ready = 1'b0;

  logic [55:0] exp_acc_q[$];
  logic [55:0] got_acc_q[$];
  logic [3:0]  exp_ovf_q[$];
  logic [3:0]  got_ovf_q[$];

  longint      m_seg[4];
  int          m_cnt = 0;
  int          m_len = 1;
  int          m_lvl = 0;
  logic [3:0]  m_ovf = '0;

  prec_scalable_mac dut (
    .clk       (clk),
    .rst       (rst),
    .mode      (mode),
    .acc_len   (acc_len),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .act       (act),
    .wgt       (wgt),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_acc   (out_acc),
    .out_ovf   (out_ovf)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog expired");
  end

  // Record every result that will transfer on the coming rising edge.
  always begin
    @(negedge clk);
    #2;
    if (!rst && out_valid && out_ready) begin
      got_acc_q.push_back(out_acc);
      got_ovf_q.push_back(out_ovf);
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 4; k++) m_seg[k] = 0;
    m_cnt = 0;
    m_ovf = '0;
  endtask

  // Reference: each run sums act*sub_weight per segment using plain integers.
  task automatic model_beat(input logic [7:0] a, input logic [7:0] w, input lvl_t md,
                            input logic [15:0] len);
    longint sa, raw, s, mx, mn;
    int nseg, segw, subw;
    logic [63:0] e, v, mask;
    if (m_cnt == 0) begin
      m_lvl = (int'(md) > 2) ? 2 : int'(md);
      m_len = (len == 0) ? 1 : int'(len);
    end
    nseg = 1 << m_lvl;
    segw = 56 >> m_lvl;
    subw = 8 >> m_lvl;
    sa   = longint'($signed(a));
    for (int k = 0; k < nseg; k++) begin
      raw = (longint'(w) >> (k * subw)) & ((64'sd1 << subw) - 1);
      if (raw >= (64'sd1 << (subw - 1))) raw = raw - (64'sd1 << subw);
      s = m_seg[k] + sa * raw;
`ifdef PSMAC_SATURATE_EN
      mx = (64'sd1 <<< (segw - 1)) - 1;
      mn = -mx - 1;
      if (s > mx) begin
        s = mx;
        m_ovf[k] = 1'b1;
      end else if (s < mn) begin
        s = mn;
        m_ovf[k] = 1'b1;
      end
`else
      mx = 0;
      mn = 0;
`endif
      m_seg[k] = s;
    end
    m_cnt++;
    if (m_cnt == m_len) begin
      e    = '0;
      mask = (64'd1 << segw) - 1;
      for (int k = 0; k < nseg; k++) begin
        v = m_seg[k];
        e = e | ((v & mask) << (k * segw));
      end
      exp_acc_q.push_back(e[55:0]);
      exp_ovf_q.push_back(m_ovf);
      model_reset();
    end
  endtask

  task automatic send(input logic [7:0] a, input logic [7:0] w, input lvl_t md,
                      input logic [15:0] len);
    int n;
    n = 0;
    @(negedge clk);
    in_valid = 1'b1;
    act      = a;
    wgt      = w;
    mode     = md;
    acc_len  = len;
    if (rnd_ready) out_ready = 1'($urandom_range(0, 1));
    #1;
    while (!in_ready && n < 100) begin
      @(negedge clk);
      if (rnd_ready) out_ready = 1'($urandom_range(0, 1));
      #1;
      n++;
    end
    if (!in_ready) chk("send_timeout", in_ready, 1);
    @(posedge clk);
    if (in_ready) model_beat(a, w, md, len);
  endtask

  task automatic wait_out(input string tag);
    int n;
    n = 0;
    @(negedge clk);
    in_valid = 1'b0;
    #1;
    while (!out_valid && n < 50) begin
      @(negedge clk);
      #1;
      n++;
    end
    chk(tag, out_valid, 1);
  endtask

  task automatic drain(input string tag);
    int n;
    n = 0;
    @(negedge clk);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    while (got_acc_q.size() != exp_acc_q.size() && n < 40) begin
      @(negedge clk);
      n++;
    end
    repeat (2) @(negedge clk);
    chk(tag, got_acc_q.size(), exp_acc_q.size());
  endtask

  initial begin
    int base;
    logic [55:0] tmp;
    lvl_t md;
    logic [15:0] len;
    int nb;

    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    mode = '0; acc_len = 16'd1; act = '0; wgt = '0;
    model_reset();
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_acc", out_acc, 0);
    chk("rst_out_ovf", out_ovf, 0);
    chk("rst_in_ready", in_ready, 1);

    // Level 0, three beats, checking result timing
    repeat (3) send(8'h80, 8'h80, 2'd0, 16'd3);
    @(negedge clk);
    in_valid = 1'b0;
    #1;
    chk("l0_not_yet", out_valid, 0);
    @(negedge clk);
    #1;
    chk("l0_valid", out_valid, 1);
    chk("l0_acc", out_acc, 49152);
    chk("l0_ovf", out_ovf, 0);
    @(negedge clk);
    #1;
    chk("l0_single", out_valid, 0);

    // Level 1, two segments with opposite signs
    repeat (2) send(8'd10, 8'h3F, 2'd1, 16'd2);
    wait_out("l1_valid");
    chk("l1_hi", out_acc[55:28], 60);
    chk("l1_lo", out_acc[27:0], 28'hFFFFFEC);

    // Level 2, four segments
    send(8'hFD, 8'h6C, 2'd2, 16'd1);
    wait_out("l2_valid");
    chk("l2_s3", out_acc[55:42], 14'h3FFD);
    chk("l2_s2", out_acc[41:28], 6);
    chk("l2_s1", out_acc[27:14], 3);
    chk("l2_s0", out_acc[13:0], 0);
    drain("drain_a");

    // Back-pressure: hold the first result, stall the second in stage 1
    base = got_acc_q.size();
    @(negedge clk);
    out_ready = 1'b0;
    send(8'd1, 8'd5, 2'd0, 16'd1);
    send(8'd2, 8'd5, 2'd0, 16'd1);
    @(negedge clk);
    in_valid = 1'b1;
    act      = 8'd3;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      #1;
      chk("bp_in_ready", in_ready, 0);
      chk("bp_hold_vld", out_valid, 1);
      chk("bp_hold_acc", out_acc, 5);
    end
    @(negedge clk);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    send(8'd3, 8'd5, 2'd0, 16'd1);
    send(8'd4, 8'd5, 2'd0, 16'd1);
    drain("drain_bp");
    chk("bp_count", got_acc_q.size() - base, 4);
    for (int i = 0; i < 4; i++) begin
      if (base + i < got_acc_q.size())
        chk($sformatf("bp_res%0d", i), got_acc_q[base + i], 5 * (i + 1));
    end

    // Reset in the middle of a run
    send(8'd7, 8'd3, 2'd0, 16'd4);
    send(8'd7, 8'd3, 2'd0, 16'd4);
    @(negedge clk);
    in_valid = 1'b0;
    rst      = 1'b1;
    model_reset();
    #1;
    chk("mrst_out_valid", out_valid, 0);
    chk("mrst_in_ready", in_ready, 1);
    @(negedge clk);
    rst = 1'b0;
    send(8'd1, 8'd1, 2'd0, 16'd1);
    wait_out("mrst_valid");
    chk("mrst_acc", out_acc, 1);
    drain("drain_rst");

    // Long level-2 run driving every segment past its range
    for (int i = 0; i < 200; i++) send(8'h80, 8'hAA, 2'd2, 16'd200);
    wait_out("sat_valid");
    tmp = out_acc;
    for (int k = 0; k < 4; k++) begin
`ifdef PSMAC_SATURATE_EN
      chk($sformatf("sat_seg%0d", k), (tmp >> (k * 14)) & 56'h3FFF, 8191);
`else
      chk($sformatf("sat_seg%0d", k), (tmp >> (k * 14)) & 56'h3FFF, 2048);
`endif
    end
`ifdef PSMAC_SATURATE_EN
    chk("sat_ovf", out_ovf, 4'b1111);
`else
    chk("sat_ovf", out_ovf, 4'b0000);
`endif
    drain("drain_sat");

    // Random runs; mid-run beats carry junk mode/length that must be ignored
    rnd_ready = 1'b1;
    for (int r = 0; r < 40; r++) begin
      md  = lvl_t'($urandom_range(0, 3));
      len = 16'($urandom_range(0, 4));
      nb  = (len == 0) ? 1 : int'(len);
      for (int b = 0; b < nb; b++) begin
        if (b == 0) send(8'($urandom), 8'($urandom), md, len);
        else send(8'($urandom), 8'($urandom), lvl_t'($urandom_range(0, 3)),
                  16'($urandom_range(0, 7)));
      end
    end
    rnd_ready = 1'b0;
    drain("drain_rnd");

    chk("sb_count", got_acc_q.size(), exp_acc_q.size());
    for (int i = 0; i < exp_acc_q.size() && i < got_acc_q.size(); i++) begin
      chk($sformatf("sb_acc%0d", i), got_acc_q[i], exp_acc_q[i]);
      chk($sformatf("sb_ovf%0d", i), got_ovf_q[i], exp_ovf_q[i]);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
